div_controller: RTL

//  Sequencing FSM for the 8-bit restoring divider; sits directly upstream of the

---
 rtl/div_if.sv | 15 +
 rtl/div_controller.sv | 64 ++++++
 2 files changed

// File: rtl/div_if.sv
// div_if: control/status bundle between the divider sequencer and its datapath
interface div_if #(parameter int CNT_W = 3);
  logic start;
  logic sign;
  logic load;
  logic add;
  logic shift;
  logic inbit;
  logic [1:0] sel;
  logic busy;
  logic done;
  logic [CNT_W-1:0] iter;
  modport master(input start, sign, output load, add, shift, inbit, sel, busy, done, iter);
  modport slave(output start, sign, input load, add, shift, inbit, sel, busy, done, iter);
endinterface

// File: rtl/div_controller.sv
// div_controller: sequencing FSM for an N_BITS restoring divider datapath
module div_controller #(
  parameter int N_BITS = 8,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic reset,
  div_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TEST, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] iter, iter_n;
  logic last;
  assign last = iter == CNT_W'(N_BITS - 1);
  assign bus.iter = iter;
  assign bus.add = 1'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      iter <= '0;
    end else begin
      state <= state_n;
      iter <= iter_n;
    end
  end
  // sel/inbit in TEST follow sign: commit the difference only when it is non-negative
  always_comb begin
    state_n = state;
    iter_n = iter;
    bus.load = 1'b0;
    bus.shift = 1'b0;
    bus.inbit = 1'b0;
    bus.sel = 2'b11;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: state_n = bus.start ? LOAD : IDLE;
      LOAD: begin
        bus.load = 1'b1;
        bus.sel = 2'b10;
        bus.busy = 1'b1;
        iter_n = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        bus.shift = 1'b1;
        bus.busy = 1'b1;
        state_n = TEST;
      end
      TEST: begin
        bus.busy = 1'b1;
        bus.inbit = ~bus.sign;
        bus.sel = bus.sign ? 2'b11 : 2'b01;
        state_n = last ? DONE : SHIFT;
        iter_n = last ? iter : iter + CNT_W'(1);
      end
      DONE: begin
        bus.done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
